handshake_rx_buf: RTL and testbench
===================================

HANDSHAKE_RX_BUF -- requirements
Module: handshake_rx_buf

Interface
REQ-001 Parameter DATA_W, default 8, shall set the payload width; the legal range is 1 to 64.
REQ-002 Parameter DEPTH, default 4, shall set the receive buffer entry count; it must be a power of two and at least 2.
REQ-003 Parameter HOLD_CYCLES, default 6, shall set how many cycles each word is presented at the output; it must be at least 1.
REQ-004 Port list (name  direction  width  meaning) shall be:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ready_in  in  1  sender has valid data on data_in.
- data_in  in  DATA_W  sender payload.
- accepted  out  1  one-cycle acknowledge to the sender.
- out_data  out  DATA_W  word currently displayed.
- out_valid  out  1  out_data is inside its hold window.
- count  out  clog2(DEPTH+1)  words currently buffered.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Function
REQ-005 The receive FSM shall have the states IDLE, LOAD, ACK and WAIT_LOW.
REQ-006 IDLE shall go to LOAD when ready_in=1 and full=0, and shall otherwise stay in IDLE.
REQ-007 LOAD shall write data_in into the buffer tail on its clock edge and shall always go to ACK.
REQ-008 ACK shall drive accepted=1 for exactly that cycle and shall always go to WAIT_LOW.
REQ-009 WAIT_LOW shall stay while ready_in=1 and shall go to IDLE when ready_in=0, so one request is never captured twice.
REQ-010 Latency: with ready_in sampled high in IDLE at cycle N, the write shall occur at the end of N+1 and accepted shall be high in cycle N+2.
REQ-011 While full=1, IDLE shall ignore ready_in and accepted shall stay 0; no data shall be lost or overwritten.
REQ-012 The buffer shall be a FIFO with wrap-around read and write pointers.
REQ-013 count shall increment on a write, decrement on a pop, and be unchanged when a write and a pop occur in the same cycle.
REQ-014 When out_valid=0 or the hold counter reaches HOLD_CYCLES-1, and empty=0, the display logic shall pop the head into out_data, set out_valid=1, and clear the hold counter.
REQ-015 When the hold counter expires and empty=1, out_valid shall drop to 0 and out_data shall retain its last value.
REQ-016 The first word shall be presented one cycle after the buffer becomes non-empty.
REQ-017 Consecutive buffered words shall be presented back-to-back, each for exactly HOLD_CYCLES cycles.
REQ-018 A write to an empty buffer in the same cycle as a pop attempt shall not be popped in that cycle; it shall be popped on the next eligible cycle.
REQ-019 The hold counter shall be clog2(HOLD_CYCLES+1) bits wide and shall not run while out_valid=0.

Reset
REQ-020 Asserting rst_n=0 shall immediately, without a clock, force: FSM=IDLE, pointers=0, count=0, empty=1, full=0, accepted=0, out_valid=0, out_data=0, hold counter=0.
REQ-021 Reset mid-transfer, including in LOAD or ACK, shall discard all buffered data.
REQ-022 After reset is released, the block shall respond to ready_in only from the first rising edge with rst_n=1.
REQ-023 Buffer storage contents need not be reset.

Configuration
REQ-024 With macro HSRX_PARITY_EN defined, the block shall add input parity_in (1 bit, even parity over data_in) and output parity_err (1 bit).
REQ-025 With HSRX_PARITY_EN defined, parity_err shall be set at the LOAD edge of any word with mismatched parity and shall remain set until reset; the word shall still be stored.
REQ-026 With HSRX_PARITY_EN undefined, parity_in, parity_err and their logic shall be absent; the remaining behaviour shall be identical.

Verification (DATA_W=8, DEPTH=4, HOLD_CYCLES=6)
REQ-027 Single transfer: ready_in=1 with data_in=8'hA5 at cycle 0, dropped after accepted -> accepted high in cycle 2 only; out_data=8'hA5 with out_valid=1 for 6 cycles, then out_valid=0.
REQ-028 Burst to full: 5 back-to-back requests 8'h01-8'h05 -> first four accepted; fifth accepted only after the first pop; outputs 01,02,03,04,05 appear each held 6 cycles, never duplicated.
REQ-029 Held request: ready_in held high for 10 cycles with data 8'h3C -> exactly one accepted pulse and count=1 until the pop.
REQ-030 Reset mid-operation: rst_n=0 during ACK with count=3 -> accepted=0, count=0, out_valid=0 asynchronously; no further output after release.
REQ-031 Pointer wrap: 9 sequential words 8'h10-8'h18 -> output order matches input order across the pointer wrap.
REQ-032 Parity (HSRX_PARITY_EN defined): word 8'h03 with parity_in=1 -> parity_err=1 after LOAD and held through later good words.

Source files
------------

// File: rtl/handshake_rx_buf.sv
// Four-phase receive handshake feeding a FIFO whose head is shown on out_data for HOLD_CYCLES cycles per word.
// Define HSRX_PARITY_EN to add the parity_in input and the sticky parity_err output.
module handshake_rx_buf #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ready_in,
    input  logic [DATA_W-1:0]            data_in,
`ifdef HSRX_PARITY_EN
    input  logic                         parity_in,
    output logic                         parity_err,
`endif
    output logic                         accepted,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACK,
        WAIT_LOW
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_en;
    logic                pop;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign accepted  = (state_q == ACK);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE:     if (ready_in && !full) state_d = LOAD;
            LOAD: begin
                wr_en   = 1'b1;
                state_d = ACK;
            end
            ACK:      state_d = WAIT_LOW;
            WAIT_LOW: if (!ready_in) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // empty is registered, so a word written this cycle cannot be popped until the next one.
    assign pop = !empty && (!out_valid_q || (hold_q == HOLD_LAST));

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        hold_d      = hold_q;
        rd_ptr_d    = rd_ptr_q;
        if (pop) begin
            out_data_d  = mem_q[rd_ptr_q];
            out_valid_d = 1'b1;
            hold_d      = '0;
            rd_ptr_d    = rd_ptr_q + 1'b1;
        end else if (out_valid_q) begin
            if (hold_q == HOLD_LAST) begin
                out_valid_d = 1'b0;
                hold_d      = '0;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_in;
    end

`ifdef HSRX_PARITY_EN
    logic parity_err_q, parity_err_d;

    always_comb begin
        parity_err_d = parity_err_q;
        if (wr_en && ((^data_in) != parity_in)) parity_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_err_q <= 1'b0;
        else        parity_err_q <= parity_err_d;
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_handshake_rx_buf.sv
// Directed bench for handshake_rx_buf (DATA_W=8, DEPTH=4, HOLD_CYCLES=6): cycle table plus stream, reset and parity sequences.
module tb_handshake_rx_buf;

    localparam int unsigned HOLD = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ready_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       accepted;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] count;
    logic       full;
    logic       empty;
`ifdef HSRX_PARITY_EN
    logic       parity_in = 1'b0;
    logic       parity_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    handshake_rx_buf #(
        .DATA_W     (8),
        .DEPTH      (4),
        .HOLD_CYCLES(6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ready_in  (ready_in),
        .data_in   (data_in),
`ifdef HSRX_PARITY_EN
        .parity_in (parity_in),
        .parity_err(parity_err),
`endif
        .accepted  (accepted),
        .out_data  (out_data),
        .out_valid (out_valid),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       rst_n;
        logic       ready;
        logic [7:0] data;
        logic       acc;
        logic [7:0] od;
        logic       ov;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
    } vec_t;

    vec_t vec[$];

    function automatic vec_t mk(input logic r, input logic rdy, input logic [7:0] d,
                                input logic acc, input logic [7:0] od, input logic ov,
                                input logic [2:0] cnt, input logic f, input logic e);
        vec_t v;
        v.rst_n = r;   v.ready = rdy; v.data = d;
        v.acc   = acc; v.od    = od;  v.ov   = ov;
        v.cnt   = cnt; v.full  = f;   v.empty = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_stream(input logic [7:0] base, input int n, input bit want_full, input string tag);
        fork
            begin : snd
                bit got;
                for (int k = 0; k < n; k++) begin
                    @(negedge clk);
                    ready_in = 1'b1;
                    data_in  = 8'(base + k);
`ifdef HSRX_PARITY_EN
                    parity_in = ^data_in;
`endif
                    got = 1'b0;
                    for (int w = 0; w < 200 && !got; w++) begin
                        @(negedge clk);
                        if (accepted) got = 1'b1;
                    end
                    chk($sformatf("%s_ack%0d", tag, k), 64'(got), 64'd1);
                    ready_in = 1'b0;
                    @(negedge clk);
                end
            end
            begin : mon
                logic [7:0] seg_d[$];
                int         seg_len[$];
                bit         in_seg;
                logic [7:0] cur;
                int         len;
                bit         saw_full;
                int         max_cnt;
                in_seg = 1'b0; cur = '0; len = 0; saw_full = 1'b0; max_cnt = 0;
                for (int c = 0; c < n * 12 + 80 && seg_d.size() < n; c++) begin
                    @(negedge clk);
                    if (full) saw_full = 1'b1;
                    if (int'(count) > max_cnt) max_cnt = int'(count);
                    if (out_valid) begin
                        if (in_seg && out_data == cur) begin
                            len++;
                        end else begin
                            if (in_seg) begin
                                seg_d.push_back(cur);
                                seg_len.push_back(len);
                            end
                            in_seg = 1'b1;
                            cur    = out_data;
                            len    = 1;
                        end
                    end else if (in_seg) begin
                        seg_d.push_back(cur);
                        seg_len.push_back(len);
                        in_seg = 1'b0;
                    end
                end
                chk($sformatf("%s_nwords", tag), 64'(seg_d.size()), 64'(n));
                for (int i = 0; i < n && i < seg_d.size(); i++) begin
                    chk($sformatf("%s_word%0d", tag, i), 64'(seg_d[i]), 64'(8'(base + i)));
                    chk($sformatf("%s_hold%0d", tag, i), 64'(seg_len[i]), 64'(HOLD));
                end
                if (want_full) begin
                    chk($sformatf("%s_saw_full", tag), 64'(saw_full), 64'd1);
                    chk($sformatf("%s_max_count", tag), 64'(max_cnt), 64'd4);
                end
                chk($sformatf("%s_end_empty", tag), 64'(empty), 64'd1);
            end
        join
    endtask

    initial begin
        vec.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1));
        // single transfer of A5
        vec.push_back(mk(1, 1, 8'hA5, 0, 8'h00, 0, 0, 0, 1));
        vec.push_back(mk(1, 1, 8'hA5, 0, 8'h00, 0, 0, 0, 1));
        vec.push_back(mk(1, 1, 8'hA5, 1, 8'h00, 0, 1, 0, 0));
        for (int i = 0; i < 6; i++) vec.push_back(mk(1, 0, 8'h00, 0, 8'hA5, 1, 0, 0, 1));
        vec.push_back(mk(1, 0, 8'h00, 0, 8'hA5, 0, 0, 0, 1));
        // ready held for ten cycles with 3C
        vec.push_back(mk(1, 1, 8'h3C, 0, 8'hA5, 0, 0, 0, 1));
        vec.push_back(mk(1, 1, 8'h3C, 0, 8'hA5, 0, 0, 0, 1));
        vec.push_back(mk(1, 1, 8'h3C, 1, 8'hA5, 0, 1, 0, 0));
        for (int i = 0; i < 6; i++) vec.push_back(mk(1, 1, 8'h3C, 0, 8'h3C, 1, 0, 0, 1));
        vec.push_back(mk(1, 1, 8'h3C, 0, 8'h3C, 0, 0, 0, 1));
        vec.push_back(mk(1, 0, 8'h00, 0, 8'h3C, 0, 0, 0, 1));
        vec.push_back(mk(1, 0, 8'h00, 0, 8'h3C, 0, 0, 0, 1));

        for (int i = 0; i < vec.size(); i++) begin
            @(negedge clk);
            rst_n    = vec[i].rst_n;
            ready_in = vec[i].ready;
            data_in  = vec[i].data;
`ifdef HSRX_PARITY_EN
            parity_in = ^vec[i].data;
`endif
            #1;
            chk($sformatf("row%0d_accepted", i),  64'(accepted),  64'(vec[i].acc));
            chk($sformatf("row%0d_out_data", i),  64'(out_data),  64'(vec[i].od));
            chk($sformatf("row%0d_out_valid", i), 64'(out_valid), 64'(vec[i].ov));
            chk($sformatf("row%0d_count", i),     64'(count),     64'(vec[i].cnt));
            chk($sformatf("row%0d_full", i),      64'(full),      64'(vec[i].full));
            chk($sformatf("row%0d_empty", i),     64'(empty),     64'(vec[i].empty));
        end

        run_stream(8'h01, 5, 1'b0, "burst");
        run_stream(8'h10, 9, 1'b0, "wrap");
        run_stream(8'h20, 16, 1'b1, "fill");

        // Reset asserted between clock edges while in ACK with three words buffered.
        begin : rst_seq
            bit fired;
            bit got;
            bit any_out;
            fired = 1'b0;
            for (int k = 0; k < 16 && !fired; k++) begin
                @(negedge clk);
                ready_in = 1'b1;
                data_in  = 8'(8'h40 + k);
`ifdef HSRX_PARITY_EN
                parity_in = ^data_in;
`endif
                got = 1'b0;
                for (int w = 0; w < 200 && !got; w++) begin
                    @(negedge clk);
                    if (accepted) got = 1'b1;
                end
                if (got && count == 3'd3) begin
                    #2 rst_n = 1'b0;
                    #1;
                    fired = 1'b1;
                    chk("rst_accepted",  64'(accepted),  64'd0);
                    chk("rst_count",     64'(count),     64'd0);
                    chk("rst_out_valid", 64'(out_valid), 64'd0);
                    chk("rst_out_data",  64'(out_data),  64'd0);
                    chk("rst_empty",     64'(empty),     64'd1);
                    chk("rst_full",      64'(full),      64'd0);
                end
                ready_in = 1'b0;
                if (!fired) @(negedge clk);
            end
            chk("rst_trigger_reached", 64'(fired), 64'd1);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            any_out = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (out_valid || count != 3'd0 || accepted) any_out = 1'b1;
            end
            chk("post_rst_quiet", 64'(any_out), 64'd0);
        end

`ifdef HSRX_PARITY_EN
        begin : par_seq
            bit got;
            chk("par_initial", 64'(parity_err), 64'd0);
            @(negedge clk);
            ready_in = 1'b1; data_in = 8'h03; parity_in = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 50 && !got; w++) begin
                @(negedge clk);
                if (accepted) got = 1'b1;
            end
            chk("par_bad_ack", 64'(got), 64'd1);
            chk("par_err_set", 64'(parity_err), 64'd1);
            ready_in = 1'b0;
            @(negedge clk);
            @(negedge clk);
            ready_in = 1'b1; data_in = 8'h05; parity_in = 1'b0;
            got = 1'b0;
            for (int w = 0; w < 50 && !got; w++) begin
                @(negedge clk);
                if (accepted) got = 1'b1;
            end
            chk("par_good_ack", 64'(got), 64'd1);
            ready_in = 1'b0;
            for (int c = 0; c < 20; c++) @(negedge clk);
            chk("par_err_sticky", 64'(parity_err), 64'd1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
